// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing, cm conversion.
// Define ULTRASONIC_MEDIAN3_EN to median-filter the last three results.
module ultrasonic_ranger #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TRIG_US      = 10,
  parameter int PERIOD_MS    = 60,
  parameter int TIMEOUT_US   = 25000,
  parameter int US_PER_CM    = 58
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] dis_data,
  output logic        dis_data_wr,
  output logic        timeout_err,
  output logic        busy
);

  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int TW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int SW = $clog2(TIMEOUT_US + 1);
  localparam int PW = $clog2(PERIOD_US + 1);
  localparam int CW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_FREQ_MHZ - 1);
  localparam logic [SW-1:0] TRIG_LAST = SW'(TRIG_US - 1);
  localparam logic [SW-1:0] TO_LAST   = SW'(TIMEOUT_US - 1);
  localparam logic [PW-1:0] PER_END   = PW'(PERIOD_US);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_US - 1);
  localparam logic [CW-1:0] CM_LAST   = CW'(US_PER_CM - 1);
  localparam logic [11:0]   CM_MAX    = 12'hFFE;
  localparam logic [11:0]   NO_RANGE  = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    REPORT,
    HOLDOFF
  } state_t;

  state_t state;
  state_t nxt;

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] st_cnt;
  logic [PW-1:0] per_cnt;
  logic [CW-1:0] sub_cnt;
  logic [11:0]   cm_cnt;
  logic [11:0]   cm_nxt;
  logic [11:0]   res_q;
  logic [11:0]   result_c;
  logic          to_q;
  logic          to_c;
  logic          echo_s1;
  logic          echo_s2;
  logic          echo_d;

  logic tick;
  logic chg;
  logic start;
  logic echo_rise;
  logic echo_fall;
  logic us_timeout;
  logic per_done;
  logic cm_wrap;
  logic enter_report;

  assign tick       = (tick_cnt == TICK_LAST);
  assign chg        = (nxt != state);
  assign start      = (nxt == TRIG) && (state != TRIG);
  assign echo_rise  = echo_s2 & ~echo_d;
  assign echo_fall  = ~echo_s2 & echo_d;
  assign us_timeout = tick && (st_cnt == TO_LAST);
  assign per_done   = (per_cnt == PER_END) ||
                      (tick && (per_cnt == PER_LAST));
  assign cm_wrap    = (state == MEASURE) && tick &&
                      (sub_cnt == CM_LAST);
  // Includes the tick of the cycle in which the fall is seen.
  assign cm_nxt     = (cm_wrap && (cm_cnt != CM_MAX)) ?
                      cm_cnt + 12'd1 : cm_cnt;
  assign enter_report = (nxt == REPORT) && (state != REPORT);

  assign trig = (state == TRIG);
  assign busy = (state != IDLE);

  always_comb begin
    nxt      = state;
    result_c = cm_nxt;
    to_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) nxt = TRIG;
      end
      TRIG: begin
        if (tick && (st_cnt == TRIG_LAST)) nxt = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          nxt = MEASURE;
        end else if (us_timeout) begin
          nxt      = REPORT;
          result_c = NO_RANGE;
          to_c     = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          nxt = REPORT;
        end else if (us_timeout) begin
          nxt      = REPORT;
          result_c = NO_RANGE;
          to_c     = 1'b1;
        end
      end
      REPORT: begin
        nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (per_done) nxt = enable ? TRIG : IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      echo_s1  <= 1'b0;
      echo_s2  <= 1'b0;
      echo_d   <= 1'b0;
      tick_cnt <= '0;
      st_cnt   <= '0;
      per_cnt  <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
      res_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state   <= nxt;
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
      if (chg || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + 1'b1;
      if (chg) st_cnt <= '0;
      else if (tick) st_cnt <= st_cnt + 1'b1;
      if (start) per_cnt <= '0;
      else if (tick && (per_cnt != PER_END)) per_cnt <= per_cnt + 1'b1;
      if (chg) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if ((state == MEASURE) && tick) begin
        sub_cnt <= cm_wrap ? '0 : sub_cnt + 1'b1;
        cm_cnt  <= cm_nxt;
      end
      if (enter_report) begin
        res_q <= result_c;
        to_q  <= to_c;
      end
    end
  end

`ifdef ULTRASONIC_MEDIAN3_EN
  logic [11:0] h0;
  logic [11:0] h1;
  logic [1:0]  hcnt;
  logic [11:0] dis_q;
  logic        wr_q;
  logic        te_q;

  function automatic logic [11:0] med3(
    input logic [11:0] a,
    input logic [11:0] b,
    input logic [11:0] c
  );
    logic [11:0] lo;
    logic [11:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo) return lo;
    if (c > hi) return hi;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      h0    <= '0;
      h1    <= '0;
      hcnt  <= '0;
      dis_q <= '0;
      wr_q  <= 1'b0;
      te_q  <= 1'b0;
    end else begin
      wr_q <= (state == REPORT);
      te_q <= (state == REPORT) & to_q;
      if (state == REPORT) begin
        dis_q <= (hcnt == 2'd2) ? med3(res_q, h0, h1) : res_q;
        h0    <= res_q;
        h1    <= h0;
        if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
      end
    end
  end

  assign dis_data    = dis_q;
  assign dis_data_wr = wr_q;
  assign timeout_err = te_q;
`else
  assign dis_data    = res_q;
  assign dis_data_wr = (state == REPORT);
  assign timeout_err = (state == REPORT) & to_q;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: planned random echo stimulus vs event model.
// Honours ULTRASONIC_MEDIAN3_EN in the same way as the design.
module tb_ultrasonic_ranger;

  localparam int MAXC = 40000;
`ifdef ULTRASONIC_MEDIAN3_EN
  localparam int LAT = 4;
  localparam bit MED = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit MED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [11:0] dis_data;
  logic        dis_data_wr;
  logic        timeout_err;
  logic        busy;

  ultrasonic_ranger #(
    .CLK_FREQ_MHZ(1),
    .TRIG_US(10),
    .PERIOD_MS(2),
    .TIMEOUT_US(1000),
    .US_PER_CM(58)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .echo(echo),
    .trig(trig),
    .dis_data(dis_data),
    .dis_data_wr(dis_data_wr),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rst_a  [MAXC];
  bit en_a   [MAXC];
  bit echo_a [MAXC];
  bit x_trig [MAXC];
  bit x_busy [MAXC];
  bit x_wr   [MAXC];
  bit x_te   [MAXC];
  int x_data [MAXC];
  int hist[$];

  int vectors = 0;
  int miscompares = 0;
  int end_cyc = MAXC - 2;
  bit ready = 1'b0;

  function automatic int median3(int p, int q, int r);
    if ((p <= q && q <= r) || (r <= q && q <= p)) return q;
    if ((q <= p && p <= r) || (r <= p && p <= q)) return p;
    return r;
  endfunction

  task automatic strobe(input int rep, input int raw, input bit to);
    int shown;
    hist.push_back(raw);
    shown = raw;
    if (MED && hist.size() >= 3)
      shown = median3(hist[$], hist[$-1], hist[$-2]);
    x_wr[rep] = 1'b1;
    x_te[rep] = to;
    for (int k = rep; k < MAXC; k++) x_data[k] = shown;
  endtask

  // kind 0: echo of w us, 1: no echo, 2: echo too long
  task automatic meas(input int e0, input int kind, input int d,
                      input int w, output int a);
    for (int k = e0; k < e0 + 10; k++) x_trig[k] = 1'b1;
    for (int k = e0; k < e0 + 2000; k++) x_busy[k] = 1'b1;
    a = e0 + 10 + d;
    if (kind == 1) begin
      strobe(e0 + 1007 + LAT, 4095, 1'b1);
    end else begin
      for (int k = a; k < a + w; k++) echo_a[k] = 1'b1;
      if (kind == 0) strobe(a + w + LAT, w / 58, 1'b0);
      else strobe(a + 1000 + LAT, 4095, 1'b1);
    end
  endtask

  task automatic do_reset(input int r);
    for (int k = r; k < r + 3; k++) rst_a[k] = 1'b1;
    for (int k = r; k < MAXC; k++) en_a[k] = 1'b0;
    for (int k = r + 1; k < MAXC; k++) begin
      echo_a[k] = 1'b0;
      x_trig[k] = 1'b0;
      x_busy[k] = 1'b0;
      x_wr[k]   = 1'b0;
      x_te[k]   = 1'b0;
      x_data[k] = 0;
    end
    hist.delete();
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, got, exp);
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
    if (cyc != t) chk("timeline", cyc, t);
  endtask

  // stimulus plan and drive
  initial begin
    int kinds[7];
    int ds[7];
    int ws[7];
    int a;
    int e0;
    int kind;
    int d;
    int w;
    int r;
    rst = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    kinds = '{0, 0, 1, 2, 0, 0, 0};
    ds    = '{100, 100, 0, 300, 50, 0, 900};
    ws    = '{580, 579, 0, 1001, 1000, 57, 58};
    for (int k = 0; k < 6; k++) rst_a[k] = 1'b1;
    for (int k = 10; k < MAXC; k++) en_a[k] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e0 = 11 + 2000 * i;
      if (i < 7) begin
        kind = kinds[i];
        d = ds[i];
        w = ws[i];
      end else if (i == 15) begin
        kind = 0;
        d = 200;
        w = 600;
      end else begin
        kind = $urandom_range(0, 5);
        d = $urandom_range(0, 900);
        if (kind >= 4) begin
          kind = kind - 3;
          w = $urandom_range(1001, 1040);
        end else begin
          kind = 0;
          w = $urandom_range(1, 1000);
        end
      end
      meas(e0, kind, d, w, a);
      if (i == 15)
        for (int k = a + 300; k < MAXC; k++) en_a[k] = 1'b0;
    end
    for (int k = 32111; k < MAXC; k++) en_a[k] = 1'b1;
    d = $urandom_range(0, 500);
    w = $urandom_range(200, 1000);
    meas(32112, 0, d, w, a);
    r = a + w / 2;
    do_reset(r);
    for (int k = r + 10; k < MAXC; k++) en_a[k] = 1'b1;
    d = $urandom_range(0, 800);
    w = $urandom_range(1, 1000);
    meas(r + 11, 0, d, w, a);
    for (int k = a + 5; k < MAXC; k++) en_a[k] = 1'b0;
    end_cyc = r + 11 + 2050;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < MAXC) begin
        rst = rst_a[cyc];
        enable = en_a[cyc];
        echo = echo_a[cyc];
      end
    end
  end

  always @(negedge clk) begin
    if (ready && cyc >= 1 && cyc <= end_cyc) begin
      vectors++;
      if (trig !== x_trig[cyc] || busy !== x_busy[cyc] ||
          dis_data_wr !== x_wr[cyc] || timeout_err !== x_te[cyc] ||
          dis_data !== 12'(x_data[cyc])) begin
        miscompares++;
        $display("FAIL cycle %0d trig/busy/wr/te/data got %b %b %b %b %0d expected %b %b %b %b %0d",
                 cyc, trig, busy, dis_data_wr, timeout_err, dis_data,
                 x_trig[cyc], x_busy[cyc], x_wr[cyc], x_te[cyc],
                 x_data[cyc]);
      end
    end
  end

  // hand-computed anchors
  initial begin
    at_cyc(3);
    chk("reset_data", int'(dis_data), 0);
    chk("reset_busy", int'(busy), 0);
    at_cyc(10);
    chk("trig_before", int'(trig), 0);
    at_cyc(11);
    chk("trig_start", int'(trig), 1);
    at_cyc(20);
    chk("trig_last", int'(trig), 1);
    at_cyc(21);
    chk("trig_end", int'(trig), 0);
    at_cyc(700 + LAT);
    chk("wr_early_10cm", int'(dis_data_wr), 0);
    at_cyc(701 + LAT);
    chk("wr_10cm", int'(dis_data_wr), 1);
    chk("data_10cm", int'(dis_data), 10);
    chk("te_10cm", int'(timeout_err), 0);
    at_cyc(702 + LAT);
    chk("wr_once_10cm", int'(dis_data_wr), 0);
    chk("data_hold", int'(dis_data), 10);
    at_cyc(2010);
    chk("trig_pre2", int'(trig), 0);
    at_cyc(2011);
    chk("trig_period", int'(trig), 1);
    at_cyc(2700 + LAT);
    chk("data_9cm", int'(dis_data), 9);
    at_cyc(5017 + LAT);
    chk("wr_early_noecho", int'(dis_data_wr), 0);
    at_cyc(5018 + LAT);
    chk("wr_noecho", int'(dis_data_wr), 1);
    chk("te_noecho", int'(timeout_err), 1);
    chk("data_noecho", int'(dis_data), MED ? 10 : 4095);
    at_cyc(7321 + LAT);
    chk("te_long", int'(timeout_err), 1);
    chk("data_long", int'(dis_data), 4095);
    at_cyc(9071 + LAT);
    chk("data_1000us", int'(dis_data), MED ? 4095 : 17);
    at_cyc(32010);
    chk("busy_before_idle", int'(busy), 1);
    at_cyc(32011);
    chk("busy_idle", int'(busy), 0);
  end

  initial begin
    wait (ready);
    while (cyc <= end_cyc + 1) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Ultrasonic ranging front end (HC-SR04 class sensor) that produces the 12-bit distance stream consumed by the LCD distance display path.
- Launches periodic trigger pulses and times the echo pulse.
- Converts the echo width to centimetres and emits one 12-bit value with a 1-cycle write strobe. The strobe connects directly to the display FIFO write side (dis_data -> core_dis_data, dis_data_wr -> core_dis_data_wr).

Parameters:
- CLK_FREQ_MHZ, 50, clock cycles per microsecond.
- TRIG_US, 10, trigger pulse width in µs.
- PERIOD_MS, 60, measurement period (trigger start to next trigger start) in ms.
- TIMEOUT_US, 25000, maximum wait for the echo rise, and maximum echo high time, in µs.
- US_PER_CM, 58, round-trip µs per centimetre.

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, run periodic measurements while high.
- echo, input, 1, asynchronous sensor echo; synchronised internally with 2 FFs.
- trig, output, 1, sensor trigger pulse.
- dis_data, output, 12, distance in cm; 12'hFFF means out of range or timeout.
- dis_data_wr, output, 1, 1-cycle strobe; dis_data is valid in the same cycle.
- timeout_err, output, 1, 1-cycle pulse accompanying a timeout result.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset: all outputs 0 (dis_data=12'h000). State=IDLE; all counters and synchroniser FFs cleared. Reset mid-measurement aborts immediately and drops trig the next cycle.
- Timebase: the us_tick counter wraps every CLK_FREQ_MHZ cycles. It free-runs, is restarted on every state entry, and all µs/ms counts use it.
- IDLE: if enable=1, go to TRIG next cycle and start the period counter.
- TRIG: trig=1 for exactly TRIG_US µs, then trig=0 and go to WAIT_ECHO.
- WAIT_ECHO: wait for a synchronised echo rising edge, then go to MEASURE.
  - An echo already high on entry is not a rise; the block waits for low then high.
  - No rise within TIMEOUT_US -> go to REPORT with result 12'hFFF, timeout flagged.
- MEASURE:
  - The µs sub-counter counts 0..US_PER_CM-1; on wrap, the cm counter increments. This is floor division with no divider.
  - cm counter saturates at 12'hFFE. Result 12'hFFF is reserved for out-of-range/timeout only.
  - Synchronised echo falling edge -> REPORT with result = cm counter.
  - Echo high longer than TIMEOUT_US -> REPORT with 12'hFFF, timeout flagged.
- REPORT (1 cycle): dis_data <= result, dis_data_wr=1, timeout_err=flag. Then go to HOLDOFF.
  - dis_data holds its value until the next REPORT.
  - Latency from raw echo fall to strobe: 3 clk (2 sync + edge detect), ±0.
- HOLDOFF: wait until the period counter reaches PERIOD_MS, measured from TRIG entry.
  - Then enable=1 -> TRIG; enable=0 -> IDLE.
  - Deasserting enable mid-measurement never truncates; the current measurement completes and reports.
- Exactly one strobe per trigger. Strobe spacing is never less than PERIOD_MS.
- No back-pressure. The downstream FIFO absorbs at most 1 write per period.
- Period counter width: enough bits for PERIOD_MS*1000 µs. cm counter: 12 bits. µs counters: sized for TIMEOUT_US.

Optional Feature:
- Macro: ULTRASONIC_MEDIAN3_EN.
- When defined:
  - Each REPORT result enters a 3-deep history; dis_data is the median of the last 3 results.
  - Until 3 results exist after reset, dis_data is the raw result.
  - 12'hFFF entries participate in the median normally. timeout_err still reflects the raw result.
  - Adds 1 clk to the strobe latency (4 clk from raw echo fall).
- When undefined: raw result, 3-clk latency, no history registers.

Test Plan (CLK_FREQ_MHZ=1, TRIG_US=10, PERIOD_MS=2, TIMEOUT_US=1000, US_PER_CM=58):
- Reset, enable=1 -> trig high exactly 10 cycles starting 1 cycle after enable; outputs 0 before that.
- Echo high 580 cycles -> dis_data=10, dis_data_wr 1 cycle, 3 cycles after echo fall; timeout_err=0. Echo 579 cycles -> dis_data=9.
- No echo -> strobe with dis_data=12'hFFF and timeout_err=1 at 1000 µs after trig fall. Echo stuck high for 1001 µs -> same 12'hFFF result.
- enable=1 continuously -> trigger starts exactly 2000 cycles apart. Drop enable during MEASURE -> that measurement still reports, then IDLE, busy=0.
- Assert rst mid-MEASURE -> trig=0, busy=0, no strobe. Restart gives a correct new measurement.
- With ULTRASONIC_MEDIAN3_EN, echo widths giving 10, 50, 12 cm -> third strobe dis_data=12. Also check the 4-cycle latency.
